// File: rtl/cache_pkg.sv
// cache_pkg: shared FSM states, width helpers and address field extraction for nway_wb_cache.
package cache_pkg;
  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL_REQ, REFILL_WAIT} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << r) < v) r++;
    return r;
  endfunction
  localparam int OFFSET_W = clog2(4);
  localparam int INDEX_W = clog2(16);
  localparam int TAG_W = 16 - INDEX_W - OFFSET_W;
  localparam int PLRU_W = 4 - 1;
  function automatic int unsigned field(input logic [31:0] a, input int lsb, input int w);
    return (a >> lsb) & ((32'd1 << w) - 32'd1);
  endfunction
endpackage

// File: rtl/nway_wb_cache_plru.sv
// plru_tree: heap-ordered tree pseudo-LRU; victim walk and access update for one set.
module plru_tree
  import cache_pkg::*;
#(
  parameter int WAYS = 4,
  localparam int LW = clog2(WAYS)
) (
  input  logic [WAYS-2:0] bits,
  input  logic [LW-1:0]   way,
  output logic [LW-1:0]   victim,
  output logic [WAYS-2:0] next_bits
);
  logic [LW-1:0] n, m;
  always_comb begin
    next_bits = bits;
    victim = '0;
    n = '0;
    m = '0;
    for (int l = 0; l < LW; l++) begin
      victim[LW-1-l] = bits[n];
      n = LW'(2 * int'(n) + 1 + int'(bits[n]));
      next_bits[m] = ~way[LW-1-l];
      m = LW'(2 * int'(m) + 1 + int'(way[LW-1-l]));
    end
  end
endmodule

// File: rtl/nway_wb_cache.sv
// nway_wb_cache: N-way set-associative write-back/write-allocate cache with tree PLRU
// replacement, stalling the CPU while it writes back and refills word by word.
module nway_wb_cache
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int WAYS = 4,
  parameter int SETS = 16,
  parameter int WORDS_PER_BLOCK = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic                  cpu_req_write,
  input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
  input  logic [DATA_WIDTH-1:0] cpu_req_wdata,
  output logic                  cpu_resp_valid,
  output logic [DATA_WIDTH-1:0] cpu_resp_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_write,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  localparam int OW = clog2(WORDS_PER_BLOCK);
  localparam int IW = clog2(SETS);
  localparam int TW = ADDR_WIDTH - IW - OW;
  localparam int LW = clog2(WAYS);
  state_t state, next;
  logic req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [LW-1:0] victim, hit_way, inv_way, plru_victim, miss_way;
  logic [OW-1:0] cnt, off;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic hit, inv, last;
  logic [TW-1:0] tag_mem [SETS][WAYS];
  logic [DATA_WIDTH-1:0] data_mem [SETS][WAYS][WORDS_PER_BLOCK];
  logic [WAYS-1:0] valid [SETS];
  logic [WAYS-1:0] dirty [SETS];
  logic [WAYS-2:0] plru [SETS];
  logic [WAYS-2:0] plru_next;
  assign off = OW'(field(32'(req_addr), 0, OW));
  assign idx = IW'(field(32'(req_addr), OW, IW));
  assign tag = TW'(field(32'(req_addr), OW + IW, TW));
  assign last = cnt == '1;
  // Descending scan so the lowest matching / invalid way wins.
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    inv = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid[idx][w] && tag_mem[idx][w] == tag) begin
        hit = 1'b1;
        hit_way = LW'(w);
      end
      if (!valid[idx][w]) begin
        inv = 1'b1;
        inv_way = LW'(w);
      end
    end
  end
  assign miss_way = inv ? inv_way : plru_victim;
  plru_tree #(.WAYS(WAYS)) u_plru (
    .bits(plru[idx]),
    .way(hit_way),
    .victim(plru_victim),
    .next_bits(plru_next)
  );
  assign cpu_req_ready = state == IDLE;
  assign mem_req_valid = state == WRITEBACK || state == REFILL_REQ;
  assign mem_req_write = state == WRITEBACK;
  assign mem_req_addr = state == WRITEBACK ? {tag_mem[idx][victim], idx, cnt} :
                        state == REFILL_REQ ? {tag, idx, cnt} : '0;
  assign mem_req_wdata = state == WRITEBACK ? data_mem[idx][victim][cnt] : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:        next = cpu_req_valid ? LOOKUP : IDLE;
      LOOKUP:      next = hit ? IDLE : (valid[idx][miss_way] && dirty[idx][miss_way]) ? WRITEBACK : REFILL_REQ;
      WRITEBACK:   next = (mem_req_ready && last) ? REFILL_REQ : WRITEBACK;
      REFILL_REQ:  next = mem_req_ready ? REFILL_WAIT : REFILL_REQ;
      REFILL_WAIT: next = !mem_rvalid ? REFILL_WAIT : last ? LOOKUP : REFILL_REQ;
      default:     next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      req_write <= 1'b0;
      req_addr <= '0;
      req_wdata <= '0;
      victim <= '0;
      cnt <= '0;
      cpu_resp_valid <= 1'b0;
      cpu_resp_rdata <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
        plru[s] <= '0;
      end
    end else begin
      cpu_resp_valid <= 1'b0;
      case (state)
        IDLE: if (cpu_req_valid) begin
          req_write <= cpu_req_write;
          req_addr <= cpu_req_addr;
          req_wdata <= cpu_req_wdata;
        end
        LOOKUP: if (hit) begin
          cpu_resp_valid <= 1'b1;
          plru[idx] <= plru_next;
          if (req_write) dirty[idx][hit_way] <= 1'b1;
          else cpu_resp_rdata <= data_mem[idx][hit_way][off];
        end else begin
          victim <= miss_way;
          cnt <= '0;
        end
        WRITEBACK: if (mem_req_ready) begin
          cnt <= cnt + 1'b1;
          if (last) dirty[idx][victim] <= 1'b0;
        end
        REFILL_WAIT: if (mem_rvalid) begin
          cnt <= cnt + 1'b1;
          if (last) begin
            valid[idx][victim] <= 1'b1;
            dirty[idx][victim] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  // Tag and data arrays carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (state == LOOKUP && hit && req_write) data_mem[idx][hit_way][off] <= req_wdata;
    if (state == REFILL_WAIT && mem_rvalid) begin
      data_mem[idx][victim][cnt] <= mem_rdata;
      if (last) tag_mem[idx][victim] <= tag;
    end
  end
endmodule
